// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: sweeps every input vector of a function bank, streams captured rows and checks them against a golden table
module truth_table_sequencer #(
   parameter int N_IN   = 2,
   parameter int N_FN   = 5,
   parameter int SETTLE = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       abort,
   input  logic [N_FN*(2**N_IN)-1:0]  golden,
   output logic [N_IN-1:0]            vec,
   input  logic [N_FN-1:0]            fn_out,
   output logic                       row_valid,
   output logic [N_IN-1:0]            row_idx,
   output logic [N_FN-1:0]            row_data,
   output logic                       busy,
   output logic                       done,
   output logic [N_FN-1:0]            mismatch,
   output logic                       pass
);
   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURE} state_t;
   state_t                     state, state_next;
   logic [7:0]                 cnt;
   logic [N_FN*(2**N_IN)-1:0]  golden_reg;
   logic [N_FN-1:0]            gold_row, mism_next;
   logic                       last;
   assign last      = &vec;
   assign gold_row  = N_FN'(golden_reg >> (vec * N_FN));
   assign mism_next = mismatch | (fn_out ^ gold_row);
   // SETTLE state lasts max(SETTLE,1) cycles, so a row is held for that plus the capture cycle
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:    state_next = start ? ST_SETTLE : ST_IDLE;
         ST_SETTLE:  state_next = abort ? ST_IDLE : (cnt > 8'd1 ? ST_SETTLE : ST_CAPTURE);
         ST_CAPTURE: state_next = (abort || last) ? ST_IDLE : ST_SETTLE;
         default:    state_next = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk) state <= !rst_n ? ST_IDLE : state_next;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vec        <= '0;
         cnt        <= '0;
         golden_reg <= '0;
         row_valid  <= 1'b0;
         row_idx    <= '0;
         row_data   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         mismatch   <= '0;
         pass       <= 1'b0;
      end else begin
         row_valid <= 1'b0;
         done      <= 1'b0;
         if (state == ST_IDLE) begin
            if (start) begin
               golden_reg <= golden;
               vec        <= '0;
               cnt        <= 8'(SETTLE);
               mismatch   <= '0;
               pass       <= 1'b0;
               busy       <= 1'b1;
            end
         end else if (abort) begin
            vec      <= '0;
            mismatch <= '0;
            pass     <= 1'b0;
            busy     <= 1'b0;
         end else if (state == ST_SETTLE) begin
            if (cnt > 8'd1) cnt <= cnt - 8'd1;
         end else begin
            row_data  <= fn_out;
            row_idx   <= vec;
            row_valid <= 1'b1;
            mismatch  <= mism_next;
            if (last) begin
               busy <= 1'b0;
               done <= 1'b1;
               pass <= ~|mism_next;
               vec  <= '0;
            end else begin
               vec <= vec + N_IN'(1);
               cnt <= 8'(SETTLE);
            end
         end
      end
   end
endmodule
